// File: rtl/pll_reset_sequencer.sv
// Supervisor for a PLL and its downstream clock domains: pulses the PLL reset,
// filters lock with timeout/retry, then releases per-domain resets in stages.
module pll_reset_sequencer #(
    parameter int NUM_CH         = 4,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_FILTER    = 1024,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STAGE_GAP      = 64,
    parameter int MAX_RETRIES    = 3
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              pll_lock,
    input  logic              soft_rst_req,
    output logic              pll_reset,
    output logic [NUM_CH-1:0] ch_rst,
    output logic              all_ready,
    output logic              lock_fail,
    output logic [3:0]        retry_cnt,
    output logic [7:0]        loss_cnt
);
    localparam int RW = $clog2(PLL_RST_CYCLES) + 1;
    localparam int FW = $clog2(LOCK_FILTER) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
    localparam int SW = $clog2(NUM_CH * STAGE_GAP) + 1;

    localparam logic [RW-1:0] RST_LAST  = RW'(PLL_RST_CYCLES - 1);
    localparam logic [FW-1:0] FILT_DONE = FW'(LOCK_FILTER);
    localparam logic [TW-1:0] TMO_DONE  = TW'(LOCK_TIMEOUT);
    localparam logic [SW-1:0] STG_LAST  = SW'((NUM_CH - 1) * STAGE_GAP);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t            state_q;
    logic [RW-1:0]     rst_cnt_q;
    logic [FW-1:0]     flt_q, flt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [SW-1:0]     stg_q, stg_d;
    logic              lock_meta_q, lock_s_q;
    logic              pll_reset_q;
    logic [NUM_CH-1:0] ch_rst_q, ch_rel_d;
    logic              all_ready_q;
    logic              lock_fail_q;
    logic [3:0]        retry_q, retry_d;
    logic [7:0]        loss_q, loss_d;

    // Two-flop synchroniser for the asynchronous lock input
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Counter increments and the channel mask after one release step
    always_comb begin
        flt_d    = lock_s_q ? (flt_q + FW'(1)) : {FW{1'b0}};
        tmo_d    = tmo_q + TW'(1);
        stg_d    = stg_q + SW'(1);
        retry_d  = retry_q + 4'd1;
        loss_d   = (loss_q == 8'hFF) ? loss_q : (loss_q + 8'd1);
        ch_rel_d = ch_rst_q;
        for (int i = 1; i < NUM_CH; i++) begin
            if (stg_d == SW'(i * STAGE_GAP)) begin
                ch_rel_d[i] = 1'b0;
            end else begin
                ch_rel_d[i] = ch_rst_q[i];
            end
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PLL_RST;
            rst_cnt_q   <= {RW{1'b0}};
            flt_q       <= {FW{1'b0}};
            tmo_q       <= {TW{1'b0}};
            stg_q       <= {SW{1'b0}};
            pll_reset_q <= 1'b1;
            ch_rst_q    <= {NUM_CH{1'b1}};
            all_ready_q <= 1'b0;
            lock_fail_q <= 1'b0;
            retry_q     <= 4'd0;
            loss_q      <= 8'd0;
        end else if (soft_rst_req) begin
            state_q     <= ST_PLL_RST;
            rst_cnt_q   <= {RW{1'b0}};
            pll_reset_q <= 1'b1;
            ch_rst_q    <= {NUM_CH{1'b1}};
            all_ready_q <= 1'b0;
            lock_fail_q <= 1'b0;
            retry_q     <= 4'd0;
        end else if ((state_q == ST_RELEASE || state_q == ST_RUN) && !lock_s_q) begin
            state_q     <= ST_PLL_RST;
            rst_cnt_q   <= {RW{1'b0}};
            pll_reset_q <= 1'b1;
            ch_rst_q    <= {NUM_CH{1'b1}};
            all_ready_q <= 1'b0;
            loss_q      <= loss_d;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_q     <= ST_WAIT_LOCK;
                        pll_reset_q <= 1'b0;
                        flt_q       <= {FW{1'b0}};
                        tmo_q       <= {TW{1'b0}};
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    flt_q <= flt_d;
                    tmo_q <= tmo_d;
                    // Lock acceptance is checked first so it wins a tie with timeout
                    if (flt_d == FILT_DONE) begin
                        state_q     <= ST_RELEASE;
                        stg_q       <= {SW{1'b0}};
                        ch_rst_q[0] <= 1'b0;
                    end else if (tmo_d == TMO_DONE) begin
                        retry_q <= retry_d;
                        if (retry_d == RETRY_MAX) begin
                            state_q     <= ST_FAIL;
                            lock_fail_q <= 1'b1;
                        end else begin
                            state_q     <= ST_PLL_RST;
                            rst_cnt_q   <= {RW{1'b0}};
                            pll_reset_q <= 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (stg_q == STG_LAST) begin
                        state_q     <= ST_RUN;
                        all_ready_q <= 1'b1;
                        retry_q     <= 4'd0;
                    end else begin
                        stg_q    <= stg_d;
                        ch_rst_q <= ch_rel_d;
                    end
                end
                ST_RUN: begin
                    all_ready_q <= 1'b1;
                    retry_q     <= 4'd0;
                end
                ST_FAIL: begin
                    pll_reset_q <= 1'b0;
                    ch_rst_q    <= {NUM_CH{1'b1}};
                    lock_fail_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_PLL_RST;
                    rst_cnt_q   <= {RW{1'b0}};
                    pll_reset_q <= 1'b1;
                    ch_rst_q    <= {NUM_CH{1'b1}};
                    all_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset = pll_reset_q;
    assign ch_rst    = ch_rst_q;
    assign all_ready = all_ready_q;
    assign lock_fail = lock_fail_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: bring-up, glitch, lock loss,
// timeout/fail, soft restart and asynchronous reset.
module tb_pll_reset_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       soft_rst_req;
    logic       pll_reset;
    logic [2:0] ch_rst;
    logic       all_ready;
    logic       lock_fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;
    int base;

    pll_reset_sequencer #(
        .NUM_CH        (3),
        .PLL_RST_CYCLES(4),
        .LOCK_FILTER   (8),
        .LOCK_TIMEOUT  (64),
        .STAGE_GAP     (5),
        .MAX_RETRIES   (2)
    ) dut (
        .clkin       (clk),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .soft_rst_req(soft_rst_req),
        .pll_reset   (pll_reset),
        .ch_rst      (ch_rst),
        .all_ready   (all_ready),
        .lock_fail   (lock_fail),
        .retry_cnt   (retry_cnt),
        .loss_cnt    (loss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic upto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input logic pr, input logic [2:0] ch,
                           input logic ar, input logic lf, input logic [3:0] rc,
                           input logic [7:0] lc);
        chk($sformatf("%s.pll_reset", tag), 32'(pll_reset), 32'(pr));
        chk($sformatf("%s.ch_rst", tag),    32'(ch_rst),    32'(ch));
        chk($sformatf("%s.all_ready", tag), 32'(all_ready), 32'(ar));
        chk($sformatf("%s.lock_fail", tag), 32'(lock_fail), 32'(lf));
        chk($sformatf("%s.retry_cnt", tag), 32'(retry_cnt), 32'(rc));
        chk($sformatf("%s.loss_cnt", tag),  32'(loss_cnt),  32'(lc));
    endtask

    initial begin
        reset        = 1'b1;
        pll_lock     = 1'b0;
        soft_rst_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_out("reset", 1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0);

        // Normal bring-up; base+n is the n-th rising edge after reset release
        reset = 1'b0;
        base  = cyc;
        upto(base + 3);  chk("s1.prst_hold", 32'(pll_reset), 32'd1);
        upto(base + 4);  chk("s1.prst_off",  32'(pll_reset), 32'd0);
                         chk("s1.ch_wait",   32'(ch_rst),    32'b111);
        upto(base + 13); pll_lock = 1'b1;
        upto(base + 22); chk("s1.ch_prelock", 32'(ch_rst), 32'b111);
        upto(base + 23); chk("s1.ch0_rel",    32'(ch_rst), 32'b110);
        upto(base + 27); chk("s1.ch1_wait",   32'(ch_rst), 32'b110);
        upto(base + 28); chk("s1.ch1_rel",    32'(ch_rst), 32'b100);
        upto(base + 32); chk("s1.ch2_wait",   32'(ch_rst), 32'b100);
        upto(base + 33); chk("s1.ch2_rel",    32'(ch_rst), 32'b000);
                         chk("s1.rdy_early",  32'(all_ready), 32'd0);
        upto(base + 34); chk_out("s1.run", 1'b0, 3'b000, 1'b1, 1'b0, 4'd0, 8'd0);

        // Lock loss in RUN
        upto(base + 36); pll_lock = 1'b0; base = cyc;
        upto(base + 2);  chk("s4.ch_sync",  32'(ch_rst),    32'b000);
                         chk("s4.rdy_sync", 32'(all_ready), 32'd1);
        upto(base + 3);  chk_out("s4.loss", 1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd1);
        upto(base + 6);  chk("s4.prst_hold", 32'(pll_reset), 32'd1);
        upto(base + 7);  chk("s4.prst_off",  32'(pll_reset), 32'd0);

        // Lock glitch: 6 high, 1 low, then high
        pll_lock = 1'b1;
        upto(base + 13); pll_lock = 1'b0;
        upto(base + 14); pll_lock = 1'b1;
        upto(base + 16); chk("s2.ch_glitch",  32'(ch_rst), 32'b111);
        upto(base + 23); chk("s2.ch_prelock", 32'(ch_rst), 32'b111);
        upto(base + 24); chk("s2.ch0_rel",    32'(ch_rst), 32'b110);

        // Lock loss mid-release
        upto(base + 25); pll_lock = 1'b0;
        upto(base + 27); chk("s5.ch_sync", 32'(ch_rst), 32'b110);
        upto(base + 28); chk_out("s5.loss", 1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd2);

        // Timeouts with lock held low
        upto(base + 31);  chk("s3.prst_hold", 32'(pll_reset), 32'd1);
        upto(base + 32);  chk("s3.prst_off",  32'(pll_reset), 32'd0);
        upto(base + 95);  chk("s3.w1_prst",   32'(pll_reset), 32'd0);
                          chk("s3.w1_retry",  32'(retry_cnt), 32'd0);
        upto(base + 96);  chk("s3.tmo1_prst", 32'(pll_reset), 32'd1);
                          chk("s3.tmo1_retry", 32'(retry_cnt), 32'd1);
        upto(base + 99);  chk("s3.pulse_end", 32'(pll_reset), 32'd1);
        upto(base + 100); chk("s3.w2_prst",   32'(pll_reset), 32'd0);
        upto(base + 163); chk("s3.w2_lf",     32'(lock_fail), 32'd0);
                          chk("s3.w2_retry",  32'(retry_cnt), 32'd1);
        upto(base + 164); chk_out("s3.fail", 1'b0, 3'b111, 1'b0, 1'b1, 4'd2, 8'd2);
        pll_lock = 1'b1;
        upto(base + 180); chk_out("s3.fail_held", 1'b0, 3'b111, 1'b0, 1'b1, 4'd2, 8'd2);
        pll_lock = 1'b0;
        upto(base + 184);

        // Soft restart out of FAIL
        soft_rst_req = 1'b1; base = cyc;
        upto(base + 1); soft_rst_req = 1'b0;
        chk_out("s6.soft_fail", 1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd2);
        upto(base + 5);   chk("s6.prst_off",  32'(pll_reset), 32'd0);
        upto(base + 69);  chk("s6.tmo_retry", 32'(retry_cnt), 32'd1);
                          chk("s6.tmo_prst",  32'(pll_reset), 32'd1);
        upto(base + 136); chk("s6.pre_retry", 32'(retry_cnt), 32'd1);
                          chk("s6.pre_prst",  32'(pll_reset), 32'd0);

        // Soft restart on the cycle the second timeout would fire
        soft_rst_req = 1'b1;
        upto(base + 137); soft_rst_req = 1'b0;
        chk_out("s6.soft_tmo", 1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd2);
        upto(base + 140); chk("s6.prst_hold2", 32'(pll_reset), 32'd1);
        upto(base + 141); chk("s6.prst_off2",  32'(pll_reset), 32'd0);
        pll_lock = 1'b1;
        upto(base + 150); chk("s6.ch_prelock", 32'(ch_rst), 32'b111);
        upto(base + 151); chk("s6.ch0_rel",    32'(ch_rst), 32'b110);
        upto(base + 156); chk("s6.ch1_rel",    32'(ch_rst), 32'b100);

        // Asynchronous reset between clock edges
        #1 reset = 1'b1;
        #1 chk_out("s6.async_rst", 1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0);
        upto(cyc + 2);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
